// File: rtl/mips_pkg.sv
// Shared EX-stage encodings: ALUOp classes, R-type Funct codes, ALUControl selects
// and the multiply/divide sequencer states.
package mips_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ADDI  = 2'b11;

   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_MUL   = 6'b011100;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b100;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b110;
   localparam logic [2:0] ALU_MUL = 3'b101;

   typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_FIX} md_state_t;

   function automatic logic is_md_op(input logic [5:0] f);
      return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
   endfunction

endpackage

// File: rtl/alu_decoder_muldiv_md_iter_core.sv
// Radix-2 iterative multiply (shift-add) / divide (restoring) with sign fix-up,
// producing HI/LO WIDTH+1 edges after the start edge.
module md_iter_core
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_div,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   md_state_t          state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   // MUL: {partial product, multiplier}; DIV: {remainder, dividend -> quotient}
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opb;
   logic               op_div, neg_q, neg_r, div_zero;

   logic [WIDTH-1:0]   abs_a, abs_b, div_diff, quo, rem, res_hi, res_lo;
   logic [WIDTH:0]     mul_sum, rem_sh;
   logic [2*WIDTH-1:0] div_next, prod;

   assign busy = (state != MD_IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         MD_IDLE: if (start) state_nxt = is_div ? MD_DIV : MD_MUL;
         MD_MUL,
         MD_DIV:  if (cnt == CNT_W'(1)) state_nxt = MD_FIX;
         MD_FIX:  state_nxt = MD_IDLE;
         default: state_nxt = MD_IDLE;
      endcase
   end

   always_comb begin
      abs_a    = (is_signed && a[WIDTH-1]) ? -a : a;
      abs_b    = (is_signed && b[WIDTH-1]) ? -b : b;
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
      rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      // the trial difference is below the divisor, so WIDTH bits hold it exactly
      div_diff = rem_sh[WIDTH-1:0] - opb;
      if (rem_sh >= {1'b0, opb})
         div_next = {div_diff, acc[WIDTH-2:0], 1'b1};
      else
         div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      prod = neg_q ? -acc : acc;
      quo  = acc[WIDTH-1:0];
      rem  = acc[2*WIDTH-1:WIDTH];
      if (op_div) begin
         res_lo = div_zero ? '1 : (neg_q ? -quo : quo);
         res_hi = neg_r ? -rem : rem;
      end else begin
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= MD_IDLE;
         cnt      <= '0;
         acc      <= '0;
         opb      <= '0;
         op_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= (state == MD_FIX);
         case (state)
            MD_IDLE: if (start) begin
               cnt      <= CNT_W'(WIDTH);
               op_div   <= is_div;
               neg_q    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               neg_r    <= is_signed & a[WIDTH-1];
               div_zero <= (b == '0);
               acc      <= {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
               opb      <= is_div ? abs_b : abs_a;
            end
            MD_MUL: begin
               acc <= {mul_sum, acc[WIDTH-1:1]};
               cnt <= cnt - 1'b1;
            end
            MD_DIV: begin
               acc <= div_next;
               cnt <= cnt - 1'b1;
            end
            MD_FIX: begin
               hi <= res_hi;
               lo <= res_lo;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/alu_decoder_muldiv.sv
// EX-stage ALU decoder plus HI/LO multiply/divide unit with stall generation
// for MD-dependent instructions arriving while a sequence is running.
module alu_decoder_muldiv
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Valid,
   input  logic [1:0]       ALUOp,
   input  logic [5:0]       Funct,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic [2:0]       ALUControl,
   output logic             MdStall,
   output logic             MdBusy,
   output logic             MdDone,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   logic rtype, md_start, md_dep;

   always_comb begin
      ALUControl = ALU_ADD;
      case (ALUOp)
         ALUOP_ADD:  ALUControl = ALU_ADD;
         ALUOP_SUB:  ALUControl = ALU_SUB;
         ALUOP_ADDI: ALUControl = ALU_ADD;
         ALUOP_RTYPE: begin
            case (Funct)
               F_ADD:   ALUControl = ALU_ADD;
               F_SUB:   ALUControl = ALU_SUB;
               F_AND:   ALUControl = ALU_AND;
               F_OR:    ALUControl = ALU_OR;
               F_SLT:   ALUControl = ALU_SLT;
               F_MUL:   ALUControl = ALU_MUL;
               default: ALUControl = ALU_ADD;
            endcase
         end
         default:    ALUControl = ALU_ADD;
      endcase
   end

   assign rtype    = Valid && (ALUOp == ALUOP_RTYPE);
   assign md_start = rtype && is_md_op(Funct) && !MdBusy;
   assign md_dep   = is_md_op(Funct) || (Funct == F_MFHI) || (Funct == F_MFLO);
   assign MdStall  = MdBusy && rtype && md_dep;

   md_iter_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk       (CLK),
      .rst       (RST),
      .start     (md_start),
      .is_div    (Funct[1]),
      .is_signed (~Funct[0]),
      .a         (SrcA),
      .b         (SrcB),
      .busy      (MdBusy),
      .done      (MdDone),
      .hi        (Hi),
      .lo        (Lo)
   );

endmodule

// File: tb/tb_alu_decoder_muldiv.sv
// Self-checking bench: directed MD operations feed an expected-result queue that a
// monitor drains on every MdDone pulse; decode, stall and reset checks are inline.
module tb_alu_decoder_muldiv;

   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_MUL   = 6'b011100;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;

   logic        CLK = 1'b0;
   logic        RST;
   logic        Valid;
   logic [1:0]  ALUOp;
   logic [5:0]  Funct;
   logic [31:0] SrcA, SrcB;
   logic [2:0]  ALUControl;
   logic        MdStall, MdBusy, MdDone;
   logic [31:0] Hi, Lo;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;

   alu_decoder_muldiv #(.WIDTH(32)) dut (
      .CLK(CLK), .RST(RST), .Valid(Valid), .ALUOp(ALUOp), .Funct(Funct),
      .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .MdStall(MdStall),
      .MdBusy(MdBusy), .MdDone(MdDone), .Hi(Hi), .Lo(Lo)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      else
         passed++;
   endtask

   task automatic push(input string name, input logic [31:0] hi, input logic [31:0] lo);
      exp_t e;
      e.name = name; e.hi = hi; e.lo = lo;
      sb.push_back(e);
   endtask

   // monitor: every MdDone pulse must match the oldest outstanding operation
   always @(negedge CLK) begin
      if (MdDone) begin
         if (sb.size() == 0) begin
            total++;
            $display("FAIL done_unexpected: got MdDone=1 with no outstanding op, expected 0");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_hi"}, Hi, e.hi);
            chk({e.name, "_lo"}, Lo, e.lo);
         end
      end
   end

   task automatic dec(input logic [1:0] op, input logic [5:0] f, input logic [2:0] exp);
      ALUOp = op; Funct = f;
      #1;
      chk($sformatf("dec_%b_%b", op, f), {29'd0, ALUControl}, {29'd0, exp});
   endtask

   // present an instruction for one cycle (accepted on the following edge), then drop it
   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge CLK);
      Valid = 1'b1; ALUOp = 2'b10; Funct = f; SrcA = a; SrcB = b;
      @(negedge CLK);
      Valid = 1'b0; Funct = F_ADD;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (MdBusy && n < 100) begin
         n++;
         @(negedge CLK);
      end
   endtask

   task automatic count_stall(output int n);
      n = 0;
      #1;
      while (MdStall && n < 100) begin
         n++;
         @(negedge CLK);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      RST = 1'b1; Valid = 1'b1; ALUOp = 2'b10; Funct = F_MULT; SrcA = 32'd9; SrcB = 32'd9;
      @(negedge CLK); #1;
      chk("rst_hi", Hi, 32'h0);
      chk("rst_lo", Lo, 32'h0);
      chk("rst_busy", {31'd0, MdBusy}, 32'd0);
      chk("rst_done", {31'd0, MdDone}, 32'd0);
      chk("rst_stall", {31'd0, MdStall}, 32'd0);
      Valid = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      chk("idle_busy", {31'd0, MdBusy}, 32'd0);

      // decode sweep
      dec(2'b00, F_SUB,   3'b010);
      dec(2'b01, F_ADD,   3'b100);
      dec(2'b11, F_SLT,   3'b010);
      dec(2'b10, F_ADD,   3'b010);
      dec(2'b10, F_SUB,   3'b100);
      dec(2'b10, F_AND,   3'b000);
      dec(2'b10, F_OR,    3'b001);
      dec(2'b10, F_SLT,   3'b110);
      dec(2'b10, F_MUL,   3'b101);
      dec(2'b10, 6'b111111, 3'b010);
      dec(2'b10, F_MULT,  3'b010);

      // MULT -3 * 7, Funct changes after start must not matter
      push("mult_m3x7", 32'hFFFFFFFF, 32'hFFFFFFEB);
      issue(F_MULT, 32'hFFFFFFFD, 32'd7);
      Funct = F_DIVU; SrcA = 32'd1; SrcB = 32'd1;
      wait_idle(n);
      chk("mult_busy_cycles", n, 32'd33);
      @(negedge CLK);
      chk("mult_done_once", {31'd0, MdDone}, 32'd0);

      // DIVU 100/7 followed directly by a dependent MFLO
      push("divu_100_7", 32'd2, 32'd14);
      issue(F_DIVU, 32'd100, 32'd7);
      Valid = 1'b1; ALUOp = 2'b10; Funct = F_MFLO;
      count_stall(n);
      chk("mflo_stall_cycles", n, 32'd33);
      chk("mflo_read_lo", Lo, 32'd14);
      @(negedge CLK); #1;
      chk("mflo_no_start", {31'd0, MdBusy}, 32'd0);
      Valid = 1'b0;

      // division boundary cases
      push("div_5_0", 32'd5, 32'hFFFFFFFF);
      issue(F_DIV, 32'd5, 32'd0);
      wait_idle(n);
      chk("div0_latency", n, 32'd33);
      @(negedge CLK);
      push("div_ovf", 32'd0, 32'h80000000);
      issue(F_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_idle(n);
      @(negedge CLK);
      push("div_m7_2", 32'hFFFFFFFF, 32'hFFFFFFFD);
      issue(F_DIV, 32'hFFFFFFF9, 32'd2);
      wait_idle(n);
      @(negedge CLK);

      // reset during a running MULTU discards it
      issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (9) @(negedge CLK);
      Valid = 1'b1; Funct = F_MFHI;
      RST = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, MdBusy}, 32'd0);
      chk("midrst_stall", {31'd0, MdStall}, 32'd0);
      chk("midrst_hi", Hi, 32'h0);
      chk("midrst_lo", Lo, 32'h0);
      Valid = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      repeat (40) @(negedge CLK);
      chk("midrst_stays_idle", {31'd0, MdBusy}, 32'd0);
      push("multu_max", 32'hFFFFFFFE, 32'h00000001);
      issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_idle(n);
      @(negedge CLK);

      // back-to-back MULT: the second waits, then starts in the first idle cycle
      push("mult_3x4", 32'd0, 32'd12);
      push("mult_5x6", 32'd0, 32'd30);
      @(negedge CLK);
      Valid = 1'b1; ALUOp = 2'b10; Funct = F_MULT; SrcA = 32'd3; SrcB = 32'd4;
      @(negedge CLK);
      SrcA = 32'd5; SrcB = 32'd6;
      count_stall(n);
      chk("b2b_stall_cycles", n, 32'd33);
      @(negedge CLK);
      Valid = 1'b0; Funct = F_ADD;
      #1;
      chk("b2b_second_started", {31'd0, MdBusy}, 32'd1);
      wait_idle(n);
      chk("b2b_second_cycles", n, 32'd33);
      @(negedge CLK);

      // same pair with the second invalid: no stall, no start
      push("mult_2xm1", 32'hFFFFFFFF, 32'hFFFFFFFE);
      issue(F_MULT, 32'd2, 32'hFFFFFFFF);
      Valid = 1'b0; ALUOp = 2'b10; Funct = F_MULT; SrcA = 32'd7; SrcB = 32'd7;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (MdStall) n++;
         @(negedge CLK);
      end
      chk("invalid_no_stall", n, 32'd0);
      chk("invalid_no_start", {31'd0, MdBusy}, 32'd0);

      repeat (3) @(negedge CLK);
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
